// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, optional skid entry,
// flush-to-bubble and a memory-wait freeze. Empty slots present NOP_VALUE downstream.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 96,
  parameter logic [WIDTH-1:0] NOP_VALUE = {{(WIDTH-32){1'b0}}, 32'h00000013},
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic             mmu_data_ready,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  logic             hold, accept, drain;
  logic             main_vld, skid_vld;
  logic [WIDTH-1:0] main_q;

  assign hold      = mem_valid & ~mmu_data_ready;
  assign accept    = in_valid & in_ready;
  assign drain     = main_vld & out_ready & ~hold;
  assign out_valid = main_vld;
  assign out_data  = main_q;
  assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

  generate
    if (SKID) begin : g_skid
      logic [WIDTH-1:0] skid_q;

      // in_ready only looks at the skid slot, so it never depends on out_ready.
      assign in_ready = ~hold & ~skid_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_vld <= 1'b0;
          main_q   <= NOP_VALUE;
          skid_vld <= 1'b0;
          skid_q   <= NOP_VALUE;
        end else if (flush) begin
          main_vld <= 1'b0;
          main_q   <= NOP_VALUE;
          skid_vld <= 1'b0;
          skid_q   <= NOP_VALUE;
        end else if (!hold) begin
          if (!main_vld || drain) begin
            // Older skid entry always goes ahead of new input to keep FIFO order.
            if (skid_vld) begin
              main_vld <= 1'b1;
              main_q   <= skid_q;
              skid_vld <= accept;
              skid_q   <= accept ? in_data : NOP_VALUE;
            end else if (accept) begin
              main_vld <= 1'b1;
              main_q   <= in_data;
            end else begin
              main_vld <= 1'b0;
              main_q   <= NOP_VALUE;
            end
          end else if (accept) begin
            skid_vld <= 1'b1;
            skid_q   <= in_data;
          end
        end
      end
    end else begin : g_single
      assign in_ready = ~hold & (~main_vld | out_ready);
      assign skid_vld = 1'b0;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_vld <= 1'b0;
          main_q   <= NOP_VALUE;
        end else if (flush) begin
          main_vld <= 1'b0;
          main_q   <= NOP_VALUE;
        end else if (!hold) begin
          if (accept) begin
            main_vld <= 1'b1;
            main_q   <= in_data;
          end else if (drain) begin
            main_vld <= 1'b0;
            main_q   <= NOP_VALUE;
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: both SKID variants see the same stimulus; each lane keeps a
// queue of expected payloads and a capacity-based model of the stage.
module tb_pipe_stage_reg;
  localparam int W = 96;
  typedef logic [W-1:0] pay_t;
  localparam pay_t NOP = {64'h0, 32'h00000013};

  logic clk = 1'b0;
  logic rst_n, mem_valid, mmu_data_ready, flush, in_valid, out_ready;
  pay_t in_data;
  bit   chk_en = 1'b0;
  int   n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input pay_t act, input pay_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stage capacity: two entries with skid, one entry (pass-through on drain) without.
  function automatic bit exp_rdy(input int skid, input int n, input bit h, input bit ordy);
    if (h) return 1'b0;
    return skid != 0 ? (n < 2) : (n == 0 || ordy);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    logic       in_ready, out_valid;
    pay_t       out_data;
    logic [1:0] occupancy;
    pay_t       q[$];
    int         cnt = 0;

    pipe_stage_reg #(.WIDTH(W), .SKID(g == 1)) dut (
      .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mmu_data_ready(mmu_data_ready),
      .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
    );

    // Feeder: at each edge, account for what the stage takes in and gives out.
    initial forever begin
      @(posedge clk);
      if (chk_en) begin
        bit h, acc, drn;
        h   = mem_valid & ~mmu_data_ready;
        acc = in_valid && exp_rdy(g, cnt, h, out_ready);
        drn = cnt > 0 && out_ready && !h;
        if (flush) begin
          q.delete();
          cnt = 0;
        end else begin
          if (acc) q.push_back(in_data);
          cnt = cnt + int'(acc) - int'(drn);
        end
      end
    end

    // Monitor: mid-cycle, compare outputs and retire the head on a transfer.
    initial forever begin
      @(negedge clk);
      if (chk_en) begin
        bit h;
        h = mem_valid & ~mmu_data_ready;
        chk($sformatf("L%0d in_ready", g), pay_t'(in_ready), pay_t'(exp_rdy(g, cnt, h, out_ready)));
        chk($sformatf("L%0d occupancy", g), pay_t'(occupancy), pay_t'(cnt));
        chk($sformatf("L%0d out_valid", g), pay_t'(out_valid), pay_t'(cnt > 0));
        if (cnt == 0 || q.size() == 0) chk($sformatf("L%0d nop", g), out_data, NOP);
        else begin
          chk($sformatf("L%0d out_data", g), out_data, q[0]);
          if (out_ready && !h) void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit iv, input pay_t d, input bit ordy,
                       input bit mv, input bit mr, input bit fl);
    in_valid = iv; in_data = d; out_ready = ordy;
    mem_valid = mv; mmu_data_ready = mr; flush = fl;
    @(posedge clk); #2;
  endtask

  function automatic pay_t rnd();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic rst_chk(input string tag);
    chk({tag, " L0 out_valid"}, pay_t'(lane[0].out_valid), '0);
    chk({tag, " L1 out_valid"}, pay_t'(lane[1].out_valid), '0);
    chk({tag, " L0 out_data"},  lane[0].out_data, NOP);
    chk({tag, " L1 out_data"},  lane[1].out_data, NOP);
    chk({tag, " L0 occupancy"}, pay_t'(lane[0].occupancy), '0);
    chk({tag, " L1 occupancy"}, pay_t'(lane[1].occupancy), '0);
    chk({tag, " L0 in_ready"},  pay_t'(lane[0].in_ready), pay_t'(1));
    chk({tag, " L1 in_ready"},  pay_t'(lane[1].in_ready), pay_t'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_data = '0; out_ready = 0;
    mem_valid = 0; mmu_data_ready = 0; flush = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_chk("reset");
    rst_n = 1'b1; chk_en = 1'b1;

    // Streaming at full rate
    for (int i = 0; i < 4; i++) drive(1, pay_t'(96'hA0 + i), 1, 0, 0, 0);
    // Backpressure: three offers while blocked, then release
    for (int i = 0; i < 3; i++) drive(1, pay_t'(96'hB0 + i), 0, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 0, 0, 0);
    // Memory freeze with a held entry
    drive(1, pay_t'(96'hC0), 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, pay_t'(96'hC1), 1, 1, 0, 0);
    drive(1, pay_t'(96'hC2), 1, 1, 1, 0);
    drive(0, '0, 1, 0, 0, 0);
    drive(0, '0, 1, 0, 0, 0);
    // Flush under hold with an offered entry
    drive(1, pay_t'(96'hD0), 0, 0, 0, 0);
    drive(1, pay_t'(96'hD1), 0, 0, 0, 0);
    drive(1, pay_t'(96'hEE), 0, 1, 0, 1);
    drive(0, '0, 1, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit mv;
      mv = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0,
            mv, mv ? $urandom_range(0, 2) == 0 : 1'b0, $urandom_range(0, 29) == 0);
    end
    // Asynchronous reset mid-stream with the skid lane full
    for (int i = 0; i < 3; i++) drive(1, pay_t'(96'hF0 + i), 0, 0, 0, 0);
    chk_en = 1'b0;
    chk("pre-reset L1 occupancy", pay_t'(lane[1].occupancy), pay_t'(2));
    rst_n = 1'b0;
    #1;
    rst_chk("async reset");
    lane[0].q.delete(); lane[0].cnt = 0;
    lane[1].q.delete(); lane[1].cnt = 0;
    in_valid = 1; in_data = pay_t'(96'h1234_5678_9ABC); out_ready = 1;
    @(posedge clk); #2;
    rst_n = 1'b1; chk_en = 1'b1;
    drive(1, pay_t'(96'h1234_5678_9ABC), 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 0, 0, 0);
    chk("L0 scoreboard empty", pay_t'(lane[0].q.size()), '0);
    chk("L1 scoreboard empty", pay_t'(lane[1].q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register for the scpu datapath, generalising the fixed IF/ID latch to any payload width. It adds a valid/ready handshake, an optional one-entry skid buffer, flush-to-bubble, and a global memory-wait freeze. It sits between any two adjacent pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). An invalid slot presents a configurable NOP payload downstream.

## Interface
Parameters:
- WIDTH, 96, payload width in bits (pc + inst + pc_addr0 for IF/ID use)
- NOP_VALUE, {WIDTH{1'b0}} with low 32 bits 32'h00000013, payload driven when out_valid=0
- SKID, 1, 1 = two-entry (main + skid) full-throughput stage; 0 = single-entry stage

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mem_valid  in  1  memory access in progress this cycle
- mmu_data_ready  in  1  MMU has returned data
- flush  in  1  discard all held entries (branch/exception redirect)
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  stage accepts in_data this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  main entry holds a real instruction
- out_ready  in  1  downstream consumes main entry this cycle
- out_data  out  WIDTH  main payload, NOP_VALUE when out_valid=0
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)

## Operation
- hold = mem_valid & ~mmu_data_ready. Freezes all state; in_ready=0; a downstream transfer does not occur.
- accept = in_valid & in_ready; drain = out_valid & out_ready & ~hold.
- Priority per edge: reset > flush > hold > normal update.
- flush: out_valid, skid_valid cleared; out_data and skid payload return to NOP_VALUE. It is applied even while hold=1. in_data offered in a flush cycle is dropped. in_ready is still allowed to be 1, but the accept is ignored.
- SKID=0:
  - in_ready = ~hold & (~out_valid | out_ready).
  - On accept, main loads in_data. On drain without accept, main goes invalid (NOP_VALUE).
- SKID=1:
  - in_ready = ~hold & ~skid_valid, which does not depend on out_ready.
  - If main is empty or draining, the incoming entry goes to main: skid first if skid_valid, otherwise in_data.
  - When skid moves to main, skid empties. A simultaneous accept then loads into skid.
  - accept while main is full and not draining loads skid.
  - FIFO order is preserved at all times.
- occupancy = out_valid + skid_valid.
- Invariant: skid_valid=1 implies out_valid=1.

## Timing
- Reset (rst_n low, async): out_valid=0, out_data=NOP_VALUE, skid empty, occupancy=0.
  - in_ready is 1 once hold=0, combinationally.
  - Release of rst_n is synchronous to clk.
- Latency: in_data accepted at edge N appears on out_data after edge N (1 cycle) when main is empty.
- Throughput: 1 entry/cycle in both modes while out_ready=1.
- SKID=1 absorbs exactly one extra entry after out_ready deasserts; in_ready falls the cycle after the skid fills.
- in_ready and out_valid are the only handshake outputs. Both are glitch-free functions of registered state plus hold/out_ready.
- The payload never changes while out_valid=1 and out_ready=0, except on flush or reset.
- During hold, all outputs are stable.

## Test plan
- **Reset:** assert rst_n=0 mid-stream with occupancy=2 → immediately out_valid=0, out_data=NOP_VALUE (low word 32'h00000013), occupancy=0; after release with in_valid=1 and in_data=A, out_data=A after 1 edge.
- **Streaming, SKID=1:** in_data=A,B,C,D on consecutive cycles with out_ready=1 → out_data A,B,C,D on consecutive cycles; in_ready constant 1; occupancy stays 1.
- **Backpressure, SKID=1:** main=A; out_ready=0, then feed B and C → B is captured in skid; in_ready=0 next cycle; C is held off (occupancy=2). When out_ready=1: A, B, C are delivered in order with no loss or duplication.
- **Memory freeze:** mem_valid=1, mmu_data_ready=0 for 5 cycles with in_valid=1 and out_ready=1 → in_ready=0, and out_data and occupancy are unchanged for all 5 cycles. On the cycle after mmu_data_ready=1, normal flow resumes.
- **Flush:** occupancy=2, then flush=1 together with hold=1 and in_valid=1 (in_data=E) → next edge: occupancy=0, out_valid=0, out_data=NOP_VALUE, E dropped.
- **SKID=0 mode:** main=A, out_ready=0, in_valid=1 → in_ready=0. Setting out_ready=1 in the same cycle → in_ready=1; B replaces A at the next edge.
